// File: rtl/b4to1_serializer_pkg.sv
// Shared constants for the 4-to-1 serializer: FSM encodings, index width,
// and the first/last bit indices for both bit orders.
// Imported by b4to1_serializer and b4to1_muxer.
package b4to1_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int IDX_W = 2;

  // LSB-first order walks 00 -> 11; MSB-first order walks 11 -> 00.
  localparam logic [IDX_W-1:0] LSB_ORDER_FIRST_IDX = 2'b00;
  localparam logic [IDX_W-1:0] LSB_ORDER_LAST_IDX  = 2'b11;
  localparam logic [IDX_W-1:0] MSB_ORDER_FIRST_IDX = 2'b11;
  localparam logic [IDX_W-1:0] MSB_ORDER_LAST_IDX  = 2'b00;

  function automatic logic [IDX_W-1:0] first_idx(input bit msb_first);
    return msb_first ? MSB_ORDER_FIRST_IDX : LSB_ORDER_FIRST_IDX;
  endfunction

  function automatic logic [IDX_W-1:0] last_idx(input bit msb_first);
    return msb_first ? MSB_ORDER_LAST_IDX : LSB_ORDER_LAST_IDX;
  endfunction

endpackage

// File: rtl/b4to1_muxer.sv
// Purpose: selects one bit of a 4-bit word by a 2-bit index.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: word (4-bit data), sel (bit index), bit_out (word[sel]).
module b4to1_muxer
  import b4to1_serializer_pkg::*;
(
  input  logic [3:0]       word,
  input  logic [IDX_W-1:0] sel,
  output logic             bit_out
);

  always_comb begin
    bit_out = 1'b0;
    case (sel)
      2'b00:   bit_out = word[0];
      2'b01:   bit_out = word[1];
      2'b10:   bit_out = word[2];
      2'b11:   bit_out = word[3];
      default: bit_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/b4to1_serializer.sv
// Purpose: accepts a 4-bit word on a valid/ready input and emits it one bit per
//   output handshake, LSB-first (MSB_FIRST=0) or MSB-first (MSB_FIRST=1).
// Latency: first bit valid the cycle after input handshake; one word per 5 cycles best case.
// Backpressure: out_ready low holds index/word/z0/last; in_ready only while IDLE.
// Ports: clock, reset_ (async active-low); x3_x0/in_valid/in_ready input side;
//   z0/b1_b0/last/out_valid/out_ready output side.
module b4to1_serializer
  import b4to1_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic [3:0]       x3_x0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             z0,
  output logic [IDX_W-1:0] b1_b0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last
);

  localparam logic [IDX_W-1:0] FIRST_IDX = first_idx(MSB_FIRST);
  localparam logic [IDX_W-1:0] LAST_IDX  = last_idx(MSB_FIRST);

  state_t           state, state_nxt;
  logic [3:0]       word, word_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             sel_bit;
  logic             at_last;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      word  <= 4'b0000;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      idx   <= idx_nxt;
    end
  end

  assign at_last = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_nxt  = x3_x0;
          idx_nxt   = FIRST_IDX;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // The final bit returns to IDLE without touching idx, so it never wraps.
          if (at_last) begin
            state_nxt = IDLE;
          end else if (MSB_FIRST) begin
            idx_nxt = idx - 2'd1;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  b4to1_muxer u_muxer (
    .word    (word),
    .sel     (idx),
    .bit_out (sel_bit)
  );

  assign b1_b0 = idx;
  assign z0    = out_valid & sel_bit;
  assign last  = out_valid & at_last;

endmodule

// File: tb/tb_b4to1_serializer.sv
// Purpose: self-checking bench for b4to1_serializer, both bit orders side by side.
// Latency/backpressure: shares stimulus across an LSB-first and an MSB-first instance.
// Ports: none (top-level bench).
module tb_b4to1_serializer;

  logic       clock = 1'b0;
  logic       reset_;
  logic [3:0] x3_x0;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_l, z0_l, out_valid_l, last_l;
  logic [1:0] b1_b0_l;
  logic       in_ready_m, z0_m, out_valid_m, last_m;
  logic [1:0] b1_b0_m;

  always #5 clock = ~clock;

  b4to1_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clock     (clock),
    .reset_    (reset_),
    .x3_x0     (x3_x0),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .z0        (z0_l),
    .b1_b0     (b1_b0_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .last      (last_l)
  );

  b4to1_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clock     (clock),
    .reset_    (reset_),
    .x3_x0     (x3_x0),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .z0        (z0_m),
    .b1_b0     (b1_b0_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .last      (last_m)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a word in flight plus how many of its bits have been sent.
  bit         m_busy  = 1'b0;
  logic [3:0] m_word  = 4'b0000;
  int         m_k     = 0;
  bit         m_fresh = 1'b1;   // no word accepted since reset: index still 00

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_outputs();
    int il;
    int im;
    il = m_k;
    im = 3 - m_k;
    chk("lsb_in_ready",  in_ready_l,  !m_busy);
    chk("lsb_out_valid", out_valid_l, m_busy);
    chk("msb_in_ready",  in_ready_m,  !m_busy);
    chk("msb_out_valid", out_valid_m, m_busy);
    if (m_busy) begin
      chk("lsb_b1_b0", b1_b0_l, il);
      chk("lsb_z0",    z0_l,    m_word[il]);
      chk("lsb_last",  last_l,  m_k == 3);
      chk("msb_b1_b0", b1_b0_m, im);
      chk("msb_z0",    z0_m,    m_word[im]);
      chk("msb_last",  last_m,  m_k == 3);
    end else begin
      chk("lsb_z0_idle",   z0_l,   1'b0);
      chk("lsb_last_idle", last_l, 1'b0);
      chk("msb_z0_idle",   z0_m,   1'b0);
      chk("msb_last_idle", last_m, 1'b0);
      if (m_fresh) begin
        chk("lsb_b1_b0_rst", b1_b0_l, 2'b00);
        chk("msb_b1_b0_rst", b1_b0_m, 2'b00);
      end
    end
  endtask

  // One clock: check what is presented, drive inputs, advance the model at the edge.
  task automatic cycle(input bit iv, input logic [3:0] x, input bit ordy);
    @(negedge clock);
    check_outputs();
    in_valid  = iv;
    x3_x0     = x;
    out_ready = ordy;
    @(posedge clock);
    if (!m_busy) begin
      if (iv) begin
        m_busy  = 1'b1;
        m_word  = x;
        m_k     = 0;
        m_fresh = 1'b0;
      end
    end else if (ordy) begin
      if (m_k == 3) m_busy = 1'b0;
      else m_k++;
    end
  endtask

  initial begin
    reset_    = 1'b0;
    in_valid  = 1'b0;
    x3_x0     = 4'b0000;
    out_ready = 1'b0;

    // Reset then idle.
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
    reset_ = 1'b1;
    cycle(1'b0, 4'b0000, 1'b1);

    // Basic send 1010 with out_ready held high, both orders.
    cycle(1'b1, 4'b1010, 1'b1);
    repeat (5) cycle(1'b0, 4'b0000, 1'b1);

    // Backpressure on the second bit of 0110.
    cycle(1'b1, 4'b0110, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 1'b0);
    repeat (4) cycle(1'b0, 4'b0000, 1'b1);

    // Input changes during SEND are ignored; 1111 lands only after IDLE.
    cycle(1'b1, 4'b0000, 1'b1);
    repeat (5) cycle(1'b1, 4'b1111, 1'b1);
    repeat (4) cycle(1'b0, 4'b0000, 1'b1);

    // Mid-word reset on the third bit of 1111.
    cycle(1'b1, 4'b1111, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 1'b1);
    @(negedge clock);
    check_outputs();
    #2;
    reset_ = 1'b0;
    #1;
    m_busy  = 1'b0;
    m_k     = 0;
    m_fresh = 1'b1;
    check_outputs();
    @(posedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    repeat (4) cycle(1'b0, 4'b0000, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) != 0);
    end

    @(negedge clock);
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/b4to1_serializer.md
B4TO1_SERIALIZER -- requirements
Module: b4to1_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 0, meaning: 0 sends x3_x0[0] first, 1 sends x3_x0[3] first.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset_  input  1  asynchronous, active-low reset.
REQ-004 x3_x0  input  4  parallel word to serialize, sampled only on input handshake.
REQ-005 in_valid  input  1  upstream asserts when x3_x0 holds a word.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 z0  output  1  current serial bit.
REQ-008 b1_b0  output  2  index of the bit currently presented on z0.
REQ-009 out_valid  output  1  z0/b1_b0/last are meaningful this cycle.
REQ-010 out_ready  input  1  downstream accepts the current bit.
REQ-011 last  output  1  current bit is the final bit of the word.

Function
REQ-012 Two states SHALL exist: IDLE and SEND.
REQ-013 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is SEND.
REQ-014 Input handshake (in_valid & in_ready at a clock edge) SHALL capture x3_x0 into an internal 4-bit word register, load the index with 00 (MSB_FIRST=0) or 11 (MSB_FIRST=1), and go to SEND.
REQ-015 The first bit SHALL be valid on the cycle after the handshake (latency 1).
REQ-016 b1_b0 SHALL equal the index register.
REQ-017 z0 SHALL be word[b1_b0], combinational from registered state, gated to 0 when out_valid is 0.
REQ-018 last SHALL be 1 when out_valid is 1 and the index is 11 (MSB_FIRST=0) or 00 (MSB_FIRST=1); otherwise last SHALL be 0.
REQ-019 Output handshake (out_valid & out_ready at a clock edge) with last=0 SHALL step the index by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
REQ-020 Output handshake with last=1 SHALL return the block to IDLE, so in_ready=1 on the next cycle.
REQ-021 While out_valid is 1 and out_ready is 0, index, word, z0 and last SHALL hold stable (no bit lost or duplicated).
REQ-022 Changes to x3_x0 and in_valid during SEND SHALL be ignored.
REQ-023 The word register SHALL retain its value in IDLE.
REQ-024 The index SHALL never wrap; exactly 4 output handshakes SHALL occur per accepted word.
REQ-025 Best-case throughput SHALL be one word per 5 cycles (1 accept cycle + 4 bit cycles), with no overlap of the input handshake and the last bit.

Reset
REQ-026 reset_ low SHALL immediately, without a clock edge, force: state=IDLE, word=0000, index=00, out_valid=0, z0=0, last=0, b1_b0=00.
REQ-027 in_ready SHALL read 1 during and after reset, since state is IDLE.
REQ-028 Reset asserted mid-SEND SHALL abort the word; after release the block waits in IDLE and no residual bits are emitted.

Structure
REQ-029 A shared constants file SHALL hold: the state encodings (IDLE=0, SEND=1), the index width (2), and the first/last index values for both MSB_FIRST settings.
REQ-030 Bit selection SHALL instantiate the existing b4to1_muxer as the single sub-module, driven by the word register and the index register.
REQ-031 Sequential logic SHALL be limited to the state, word and index registers.

Verification
REQ-032 Reset then idle: reset_ low for 2 cycles, then release -> in_ready=1, out_valid=0, z0=0, b1_b0=00.
REQ-033 Basic send (MSB_FIRST=0): load x3_x0=1010 with out_ready held 1 -> z0 sequence 0,1,0,1 with b1_b0 00,01,10,11, last=1 only on the 4th bit, in_ready=1 on cycle 6.
REQ-034 MSB_FIRST=1, same word -> z0 sequence 1,0,1,0 with b1_b0 11,10,01,00.
REQ-035 Backpressure: word 0110, out_ready low for 3 cycles on the 2nd bit -> b1_b0=01 and z0=1 held for 3 cycles, then the sequence resumes; 4 bits total.
REQ-036 Ignored input: change x3_x0 to 1111 and keep in_valid=1 during SEND of word 0000 -> all 4 bits 0 and in_ready=0; 1111 is accepted only after return to IDLE.
REQ-037 Mid-word reset: assert reset_ on the 3rd bit of word 1111 -> out_valid drops asynchronously, state is IDLE after release, and no further bits appear until a new handshake.
